// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Decode-side bundle in, execute-side bundle and hazard strobes out.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  logic             ValidD;
  logic [6:0]       OpD;
  logic             RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]       ResultSrcD;
  logic [2:0]       ALUControlD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic [31:0]      RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic             PCSrcE;

  logic             ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [31:0]      RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic             StallF, StallD, FlushD;
  logic [CNT_W-1:0] stall_count, flush_count;

  modport master (
    output ValidD, OpD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD,
           RD1D, RD2D, ImmExtD, PCD, PCPlus4D, PCSrcE,
    input  ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
           ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           StallF, StallD, FlushD, stall_count, flush_count
  );

  modport slave (
    input  ValidD, OpD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ResultSrcD, ALUControlD, Rs1D, Rs2D, RdD,
           RD1D, RD2D, ImmExtD, PCD, PCPlus4D, PCSrcE,
    output ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
           ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           StallF, StallD, FlushD, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use stall, branch flush and
//            saturating stall/flush event counters.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  id_ex_stage_if.slave  bus
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;

  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_lw_stall;
  logic             w_bubble;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (bus.OpD)
      c_OP_LOAD, c_OP_IMM: w_use_rs1 = 1'b1;
      c_OP_STORE, c_OP_REG, c_OP_BRANCH: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_lw_stall = bus.ValidD & bus.ValidE & (bus.ResultSrcE == 2'b01) &
                      (bus.RdE != 5'd0) &
                      ((w_use_rs1 & (bus.Rs1D == bus.RdE)) |
                       (w_use_rs2 & (bus.Rs2D == bus.RdE)));

  // A resolved branch squashes the stalled instruction anyway, so it wins.
  assign bus.StallF = w_lw_stall & ~bus.PCSrcE;
  assign bus.StallD = w_lw_stall & ~bus.PCSrcE;
  assign bus.FlushD = bus.PCSrcE;
  assign w_bubble   = w_lw_stall | bus.PCSrcE;

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      bus.ValidE      <= 1'b0;
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.ALUControlE <= 3'b000;
      bus.Rs1E        <= 5'd0;
      bus.Rs2E        <= 5'd0;
      bus.RdE         <= 5'd0;
      bus.RD1E        <= 32'd0;
      bus.RD2E        <= 32'd0;
      bus.ImmExtE     <= 32'd0;
      bus.PCE         <= 32'd0;
      bus.PCPlus4E    <= 32'd0;
    end else begin
      // Controls of a non-valid slot are zeroed so it behaves as a NOP.
      bus.ValidE      <= bus.ValidD;
      bus.RegWriteE   <= bus.RegWriteD & bus.ValidD;
      bus.MemWriteE   <= bus.MemWriteD & bus.ValidD;
      bus.BranchE     <= bus.BranchD   & bus.ValidD;
      bus.JumpE       <= bus.JumpD     & bus.ValidD;
      bus.ALUSrcE     <= bus.ALUSrcD   & bus.ValidD;
      bus.ResultSrcE  <= bus.ValidD ? bus.ResultSrcD  : 2'b00;
      bus.ALUControlE <= bus.ValidD ? bus.ALUControlD : 3'b000;
      bus.Rs1E        <= bus.Rs1D;
      bus.Rs2E        <= bus.Rs2D;
      bus.RdE         <= bus.RdD;
      bus.RD1E        <= bus.RD1D;
      bus.RD2E        <= bus.RD2D;
      bus.ImmExtE     <= bus.ImmExtD;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (bus.StallD && (r_stall_count != '1))
        r_stall_count <= r_stall_count + 1'b1;
      if (bus.FlushD && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed vector table, counter saturation and randomized checks
//            of id_ex_stage against a behavioural pipeline model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [6:0]  op;
    logic        regwrite, memwrite, branch, jump, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pcplus4;
    logic        pcsrc;
  } d_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite, memwrite, branch, jump, alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  aluctl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pcplus4;
  } e_t;

  typedef struct packed {
    d_t         d;
    logic       exp_stall;
    logic       exp_flush;
    logic       exp_valid_next;
    logic [4:0] exp_rd_next;
  } vec_t;

  logic clk;
  logic rst_in;
  d_t   din;

  id_ex_stage_if #(.CNT_W(16)) bus16 ();
  id_ex_stage_if #(.CNT_W(4))  bus4 ();

  id_ex_stage #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(rst_in), .bus(bus16));
  id_ex_stage #(.CNT_W(4))  u_dut4  (.clk(clk), .reset(rst_in), .bus(bus4));

  always_comb begin
    bus16.ValidD = din.valid;      bus4.ValidD = din.valid;
    bus16.OpD = din.op;            bus4.OpD = din.op;
    bus16.RegWriteD = din.regwrite; bus4.RegWriteD = din.regwrite;
    bus16.MemWriteD = din.memwrite; bus4.MemWriteD = din.memwrite;
    bus16.BranchD = din.branch;    bus4.BranchD = din.branch;
    bus16.JumpD = din.jump;        bus4.JumpD = din.jump;
    bus16.ALUSrcD = din.alusrc;    bus4.ALUSrcD = din.alusrc;
    bus16.ResultSrcD = din.resultsrc; bus4.ResultSrcD = din.resultsrc;
    bus16.ALUControlD = din.aluctl;   bus4.ALUControlD = din.aluctl;
    bus16.Rs1D = din.rs1;          bus4.Rs1D = din.rs1;
    bus16.Rs2D = din.rs2;          bus4.Rs2D = din.rs2;
    bus16.RdD = din.rd;            bus4.RdD = din.rd;
    bus16.RD1D = din.rd1;          bus4.RD1D = din.rd1;
    bus16.RD2D = din.rd2;          bus4.RD2D = din.rd2;
    bus16.ImmExtD = din.imm;       bus4.ImmExtD = din.imm;
    bus16.PCD = din.pc;            bus4.PCD = din.pc;
    bus16.PCPlus4D = din.pcplus4;  bus4.PCPlus4D = din.pcplus4;
    bus16.PCSrcE = din.pcsrc;      bus4.PCSrcE = din.pcsrc;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  e_t          em;
  int unsigned stalls_seen;
  int unsigned flushes_seen;
  logic        cap_stall;
  logic        cap_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Which source registers an opcode actually reads.
  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011};
  endfunction
  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0100011, 7'b0110011, 7'b1100011};
  endfunction

  // True when the instruction in D needs the value a load in E has not yet produced.
  function automatic bit load_use(input d_t d, input e_t e);
    bit dep;
    if (!d.valid || !e.valid || e.resultsrc != 2'b01 || e.rd == 5'd0) return 1'b0;
    dep = (reads_rs1(d.op) && d.rs1 == e.rd) || (reads_rs2(d.op) && d.rs2 == e.rd);
    return dep;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit hz;
    if (rst_in) begin
      em = '0;
      stalls_seen = 0;
      flushes_seen = 0;
    end else begin
      hz = load_use(din, em);
      if (hz && !din.pcsrc) stalls_seen++;
      if (din.pcsrc) flushes_seen++;
      if (hz || din.pcsrc) em = '0;
      else begin
        em.valid     = din.valid;
        em.regwrite  = din.valid && din.regwrite;
        em.memwrite  = din.valid && din.memwrite;
        em.branch    = din.valid && din.branch;
        em.jump      = din.valid && din.jump;
        em.alusrc    = din.valid && din.alusrc;
        em.resultsrc = din.valid ? din.resultsrc : 2'b00;
        em.aluctl    = din.valid ? din.aluctl : 3'b000;
        em.rs1 = din.rs1;  em.rs2 = din.rs2;  em.rd = din.rd;
        em.rd1 = din.rd1;  em.rd2 = din.rd2;  em.imm = din.imm;
        em.pc  = din.pc;   em.pcplus4 = din.pcplus4;
      end
    end
  endtask

  task automatic compare_all();
    logic exp_stall;
    exp_stall = load_use(din, em) && !din.pcsrc;
    chk("ValidE",      64'(bus16.ValidE),      64'(em.valid));
    chk("RegWriteE",   64'(bus16.RegWriteE),   64'(em.regwrite));
    chk("MemWriteE",   64'(bus16.MemWriteE),   64'(em.memwrite));
    chk("BranchE",     64'(bus16.BranchE),     64'(em.branch));
    chk("JumpE",       64'(bus16.JumpE),       64'(em.jump));
    chk("ALUSrcE",     64'(bus16.ALUSrcE),     64'(em.alusrc));
    chk("ResultSrcE",  64'(bus16.ResultSrcE),  64'(em.resultsrc));
    chk("ALUControlE", 64'(bus16.ALUControlE), 64'(em.aluctl));
    chk("Rs1E",        64'(bus16.Rs1E),        64'(em.rs1));
    chk("Rs2E",        64'(bus16.Rs2E),        64'(em.rs2));
    chk("RdE",         64'(bus16.RdE),         64'(em.rd));
    chk("RD1E",        64'(bus16.RD1E),        64'(em.rd1));
    chk("RD2E",        64'(bus16.RD2E),        64'(em.rd2));
    chk("ImmExtE",     64'(bus16.ImmExtE),     64'(em.imm));
    chk("PCE",         64'(bus16.PCE),         64'(em.pc));
    chk("PCPlus4E",    64'(bus16.PCPlus4E),    64'(em.pcplus4));
    chk("StallF",      64'(bus16.StallF),      64'(exp_stall));
    chk("StallD",      64'(bus16.StallD),      64'(exp_stall));
    chk("FlushD",      64'(bus16.FlushD),      64'(din.pcsrc));
    chk("stall_count16", 64'(bus16.stall_count), 64'(sat(stalls_seen, 16'hFFFF)));
    chk("flush_count16", 64'(bus16.flush_count), 64'(sat(flushes_seen, 16'hFFFF)));
    chk("ValidE_w4",     64'(bus4.ValidE),       64'(em.valid));
    chk("StallD_w4",     64'(bus4.StallD),       64'(exp_stall));
    chk("stall_count4",  64'(bus4.stall_count),  64'(sat(stalls_seen, 15)));
    chk("flush_count4",  64'(bus4.flush_count),  64'(sat(flushes_seen, 15)));
  endtask

  // One clock: drive, check combinational/registered state mid-cycle, advance model.
  task automatic cycle(input d_t d, input logic r, input bit do_chk);
    din = d;
    rst_in = r;
    @(negedge clk);
    cap_stall = bus16.StallD;
    cap_flush = bus16.FlushD;
    if (do_chk) compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic d_t mk(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [1:0] rsrc, input logic pcsrc,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] pc);
    d_t d;
    d = '0;
    d.valid = v;  d.op = op;  d.rs1 = rs1;  d.rs2 = rs2;  d.rd = rd;
    d.regwrite = 1'b1;  d.resultsrc = rsrc;  d.pcsrc = pcsrc;
    d.rd1 = rd1;  d.rd2 = rd2;  d.pc = pc;  d.pcplus4 = pc + 32'd4;
    d.alusrc = (op == 7'b0000011);
    return d;
  endfunction

  function automatic d_t rand_d();
    d_t d;
    logic [6:0] ops [8];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;
    ops[4] = 7'b0010011; ops[5] = 7'b1101111; ops[6] = 7'b0110111; ops[7] = 7'($urandom);
    d = d_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    d.op = ops[$urandom_range(0, 7)];
    d.valid = ($urandom_range(0, 7) != 0);
    d.rs1 = 5'($urandom_range(0, 3));
    d.rs2 = 5'($urandom_range(0, 3));
    d.rd  = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) d.resultsrc = 2'b01;
    d.pcsrc = ($urandom_range(0, 7) == 0);
    return d;
  endfunction

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{mk(1, ADD, 1, 2, 3, 2'b00, 0, 32'h11, 32'h22, 32'h40), 0, 0, 1, 5'd3};
    vecs[1] = '{mk(1, LW,  1, 0, 5, 2'b01, 0, 32'h0,  32'h0,  32'h44), 0, 0, 1, 5'd5};
    vecs[2] = '{mk(1, ADD, 5, 0, 6, 2'b00, 0, 32'h5,  32'h0,  32'h48), 1, 0, 0, 5'd0};
    vecs[3] = '{mk(1, ADD, 5, 0, 6, 2'b00, 0, 32'h5,  32'h0,  32'h48), 0, 0, 1, 5'd6};
    vecs[4] = '{mk(1, LW,  1, 0, 0, 2'b01, 0, 32'h0,  32'h0,  32'h4C), 0, 0, 1, 5'd0};
    vecs[5] = '{mk(1, ADD, 0, 0, 6, 2'b00, 0, 32'h0,  32'h0,  32'h50), 0, 0, 1, 5'd6};
    vecs[6] = '{mk(1, LW,  1, 0, 5, 2'b01, 0, 32'h0,  32'h0,  32'h54), 0, 0, 1, 5'd5};
    vecs[7] = '{mk(1, LUI, 5, 5, 7, 2'b00, 0, 32'h0,  32'h0,  32'h58), 0, 0, 1, 5'd7};
    vecs[8] = '{mk(1, LW,  1, 0, 5, 2'b01, 0, 32'h0,  32'h0,  32'h5C), 0, 0, 1, 5'd5};
    vecs[9] = '{mk(1, ADD, 5, 0, 6, 2'b00, 1, 32'h0,  32'h0,  32'h60), 0, 1, 0, 5'd0};

    din = '0;
    rst_in = 1'b1;
    em = '0;
    stalls_seen = 0;
    flushes_seen = 0;
    #1;

    cycle(rand_d(), 1'b1, 1'b0);
    cycle(rand_d(), 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].d, 1'b0, 1'b1);
      chk($sformatf("vec%0d_stall", i), 64'(cap_stall), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_flush", i), 64'(cap_flush), 64'(vecs[i].exp_flush));
      chk($sformatf("vec%0d_validE", i), 64'(bus16.ValidE), 64'(vecs[i].exp_valid_next));
      chk($sformatf("vec%0d_rdE", i), 64'(bus16.RdE), 64'(vecs[i].exp_rd_next));
    end
    chk("tbl_pcplus4E_after_add", 64'(bus16.PCPlus4E), 64'h0);
    chk("tbl_stall_count", 64'(bus16.stall_count), 64'd1);
    chk("tbl_flush_count", 64'(bus16.flush_count), 64'd1);

    for (int i = 0; i < 20; i++) begin
      cycle(mk(1, LW,  1, 0, 5, 2'b01, 0, 32'h0, 32'h0, 32'h100), 1'b0, 1'b1);
      cycle(mk(1, ADD, 5, 0, 6, 2'b00, 0, 32'h0, 32'h0, 32'h104), 1'b0, 1'b1);
      cycle(mk(1, ADD, 5, 0, 6, 2'b00, 0, 32'h0, 32'h0, 32'h104), 1'b0, 1'b1);
    end
    chk("sat_stall_count4", 64'(bus4.stall_count), 64'hF);
    chk("sat_stall_count16", 64'(bus16.stall_count), 64'd21);

    cycle(rand_d(), 1'b1, 1'b1);
    chk("reset_stall_count4", 64'(bus4.stall_count), 64'd0);
    chk("reset_flush_count16", 64'(bus16.flush_count), 64'd0);
    chk("reset_validE", 64'(bus16.ValidE), 64'd0);

    for (int i = 0; i < 600; i++)
      cycle(rand_d(), ($urandom_range(0, 49) == 0), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
